muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MULTU/DIVU in the EXECUTE stage.
- Time-shares the existing 32-bit ALU, which it drives in add (010) and subtract (110) modes, and owns the architectural HI/LO registers.
- Multiply is shift-add; divide is restoring. One iteration per clock.
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, WIDTH, iterations per operation.
- CNT_W, $clog2(ITER+1), iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
- rs_val  in  WIDTH  multiplicand/dividend; MTHI/MTLO source
- rt_val  in  WIDTH  multiplier/divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO become final
- div_zero  out  1  sticky until next start; last DIVU had divisor 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_control  out  3  ALU operation select
- alu_result  in  WIDTH  combinational ALU result, same cycle

Behaviour:
Reset (async, rst_n=0, any time including mid-operation):
- state=IDLE; busy, done, div_zero = 0; hi, lo, counter = 0.
- alu_a = alu_b = 0; alu_control = ADD.

Idle ALU drive:
- When not RUN: alu_a=0, alu_b=0, alu_control=ADD (010).

FSM: IDLE -> RUN -> IDLE.
- IDLE, start & op=MTHI: hi<=rs_val next edge. No busy, no done.
- IDLE, start & op=MTLO: lo<=rs_val next edge. No busy, no done.
- IDLE, start & op in {MULTU, DIVU}:
  - Latch M=rt_val; counter<=ITER.
  - MULTU: hi<=0, lo<=rs_val. DIVU: hi<=0, lo<=rs_val.
  - div_zero<=(op==DIVU && rt_val==0); cleared on every accepted start.
  - -> RUN.
- RUN, each cycle: one iteration, counter decrements. When counter reaches 1, the update is final -> IDLE with done=1 on the following cycle.

MULTU iteration:
- alu_a=hi, alu_b=M, control=ADD.
- If lo[0]: carry=(alu_result <u hi); {hi,lo}<={carry,alu_result,lo}>>1.
- Else: {hi,lo}<={1'b0,hi,lo}>>1.

DIVU iteration:
- Shift {top,hi,lo}={hi,lo}<<1, where top = old hi[WIDTH-1].
- alu_a=shifted hi; alu_b=M; control=SUB.
- If top | (shifted hi >=u M): hi<=alu_result, lo[0]<=1.
- Else: hi<=shifted hi, lo[0]<=0.
- Divisor 0 needs no special path: result lo=all ones, hi=dividend.

Timing:
- start sampled at edge N; busy=1 for cycles N+1..N+ITER.
- done=1 and final hi/lo visible in cycle N+ITER+1, where busy=0.
- hi/lo are intermediate while busy and valid only when busy=0.

Boundaries:
- start while busy: ignored, no effect on operation or div_zero.
- start in the done cycle: accepted, so back-to-back operations are allowed.
- MTHI/MTLO while busy: ignored.
- Product 0xFFFFFFFF*0xFFFFFFFF must produce correct carry on every iteration.
- Widths: all arithmetic is unsigned; the carry/borrow bit is held locally, not in the ALU.

Decomposition:
- Shared package mips_pkg:
  - ALU control constants ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111.
  - MD_OP encodings.
  - FSM state encoding.
- No sub-module: the ALU stays external and is reused. The iteration counter is inline.

Test Plan:
- MULTU rs=7, rt=6 -> busy 32 cycles, done pulse, hi=0x00000000, lo=0x0000002A.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2, div_zero=0. Then DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1.
- Start MULTU 3*5; pulse start DIVU at cycle 10 -> ignored, lo=15. Then start again in the done cycle -> accepted, busy next cycle.
- MTHI 0xDEADBEEF then MTLO 0x0BADF00D -> hi/lo updated one edge after each, busy and done stay 0.
- rst_n low mid-MULTU (cycle 16), asynchronous to clk -> busy, done, hi, lo = 0 immediately. After release, a new MULTU 2*2 gives lo=4.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU control codes, MULTU/DIVU/MTHI/MTLO
// encodings and the muldiv sequencer state type.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MTHI  = 2'b10;
  localparam logic [1:0] MD_MTLO  = 2'b11;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer that borrows the EXECUTE-stage ALU and
// owns HI/LO. Shift-add multiply, restoring divide, one iteration per clock.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH,
  parameter int unsigned CNT_W = $clog2(ITER + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  // Divide view of {hi,lo} shifted left by one; top is the bit shifted out.
  logic             top;
  logic [WIDTH-1:0] sh_hi;
  logic [WIDTH-1:0] sh_lo;
  logic             carry;

  assign top   = hi_q[WIDTH-1];
  assign sh_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign sh_lo = {lo_q[WIDTH-2:0], 1'b0};
  // Unsigned add overflowed iff the sum wrapped below an operand.
  assign carry = (alu_result < hi_q);

  // ALU drive is kept apart from next-state logic so alu_result never
  // feeds back into the block that produces alu_a/alu_b.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    if (state_q == StRun) begin
      alu_b = m_q;
      if (is_div_q) begin
        alu_a       = sh_hi;
        alu_control = ALU_SUB;
      end else begin
        alu_a       = hi_q;
        alu_control = ALU_ADD;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op)
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            MD_MULTU, MD_DIVU: begin
              m_d        = rt_val;
              cnt_d      = CNT_W'(ITER);
              hi_d       = '0;
              lo_d       = rs_val;
              is_div_d   = (op == MD_DIVU);
              div_zero_d = (op == MD_DIVU) && (rt_val == '0);
              state_d    = StRun;
            end
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          // With top set the true remainder exceeds M, and the wrapped
          // difference is still exact because it is smaller than M.
          if (top || (sh_hi >= m_q)) begin
            hi_d = alu_result;
            lo_d = {sh_lo[WIDTH-1:1], 1'b1};
          end else begin
            hi_d = sh_hi;
            lo_d = sh_lo;
          end
        end else if (lo_q[0]) begin
          hi_d = {carry, alu_result[WIDTH-1:1]};
          lo_d = {alu_result[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected HI/LO/div_zero,
// a monitor pops and compares on every done pulse. Includes a simple ALU.
module tb_muldiv_seq;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  int   pushed = 0;
  int   dones  = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse retires the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      dones++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending op");
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_dz"}, 32'(div_zero), 32'(e.dz));
      end
    end
  end

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input string nm);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz; e.name = nm;
    sb.push_back(e);
    pushed++;
  endtask

  // Called away from posedge; returns 1ns after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts remaining busy cycles; returns at the negedge of the first idle cycle.
  task automatic wait_idle(input string nm, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got busy after %0d cycles want idle", nm, n);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input string nm);
    int n;
    push_exp(eh, el, edz, nm);
    issue(o, a, b);
    check({nm, "_busy_next"}, 32'(busy), 32'd1);
    check({nm, "_aluctl"}, 32'(alu_control), (o == MD_DIVU) ? 32'(ALU_SUB) : 32'(ALU_ADD));
    wait_idle(nm, n);
    check({nm, "_cycles"}, n, 32'd32);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    #3 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_aluctl", 32'(alu_control), 32'b010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MD_MULTU, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, "mul_7x6");
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, "mul_max");
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div_100_7");
    run_op(MD_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1, "div_by0");
    check("dz_sticky", 32'(div_zero), 32'd1);

    // DIVU by zero pulsed mid-MULTU must be ignored entirely.
    push_exp(32'h0, 32'd15, 1'b0, "mul_3x5");
    issue(MD_MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    issue(MD_DIVU, 32'd1, 32'd0);
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_dz", 32'(div_zero), 32'd0);
    wait_idle("mul_3x5", n);
    check("b2b_done", 32'(done), 32'd1);
    run_op(MD_MULTU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, "mul_b2b");

    issue(MD_MTHI, 32'hDEADBEEF, 32'd0);
    check("mthi_hi", hi, 32'hDEADBEEF);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_done", 32'(done), 32'd0);
    @(negedge clk);
    issue(MD_MTLO, 32'h0BADF00D, 32'd0);
    check("mtlo_lo", lo, 32'h0BADF00D);
    check("mtlo_hi", hi, 32'hDEADBEEF);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_done", 32'(done), 32'd0);
    @(negedge clk);

    // MTHI while busy must not disturb the running multiply.
    push_exp(32'h0, 32'd1, 1'b0, "mul_mthi_busy");
    issue(MD_MULTU, 32'd1, 32'd1);
    repeat (2) @(negedge clk);
    issue(MD_MTHI, 32'h00000055, 32'd0);
    wait_idle("mul_mthi_busy", n);

    // Asynchronous reset in the middle of a multiply.
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (15) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_aluctl", 32'(alu_control), 32'b010);
    #3 rst_n = 1'b1;
    @(negedge clk);
    run_op(MD_MULTU, 32'd2, 32'd2, 32'h0, 32'd4, 1'b0, "mul_after_rst");

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    check("done_count", dones, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
